// File: rtl/sdram_pkg.sv
// SDRAM command opcodes and their active-low {ras,cas,we} pin encodings.
// Shared between the controller core and the pin-side I/O stage.
package sdram_pkg;

    typedef enum logic [2:0] {
        CMD_NOP       = 3'd0,
        CMD_ACTIVE    = 3'd1,
        CMD_READ      = 3'd2,
        CMD_WRITE     = 3'd3,
        CMD_PRECHARGE = 3'd4,
        CMD_REFRESH   = 3'd5,
        CMD_LOAD_MODE = 3'd6
    } sdram_cmd_t;

    localparam logic [2:0] RCW_NOP       = 3'b111;
    localparam logic [2:0] RCW_ACTIVE    = 3'b011;
    localparam logic [2:0] RCW_READ      = 3'b101;
    localparam logic [2:0] RCW_WRITE     = 3'b100;
    localparam logic [2:0] RCW_PRECHARGE = 3'b010;
    localparam logic [2:0] RCW_REFRESH   = 3'b001;
    localparam logic [2:0] RCW_LOAD_MODE = 3'b000;

    // Raw opcode in, pin pattern out; anything outside the enum decodes as NOP.
    function automatic logic [2:0] cmd_to_rcw(input logic [2:0] op);
        logic [2:0] rcw;
        rcw = RCW_NOP;
        case (op)
            3'(CMD_ACTIVE):    rcw = RCW_ACTIVE;
            3'(CMD_READ):      rcw = RCW_READ;
            3'(CMD_WRITE):     rcw = RCW_WRITE;
            3'(CMD_PRECHARGE): rcw = RCW_PRECHARGE;
            3'(CMD_REFRESH):   rcw = RCW_REFRESH;
            3'(CMD_LOAD_MODE): rcw = RCW_LOAD_MODE;
            default:           rcw = RCW_NOP;
        endcase
        return rcw;
    endfunction

endpackage

// File: rtl/sdram_rd_pipe.sv
// Valid+tag shift register that tracks outstanding reads until their data
// is due at the input capture flop.
module sdram_rd_pipe #(
    parameter int DEPTH = 3,
    parameter int TAG_W = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    input  logic [TAG_W-1:0] in_tag_i,
    output logic             out_valid_o,
    output logic [TAG_W-1:0] out_tag_o
);

    logic [DEPTH-1:0] valid_q;
    logic [TAG_W-1:0] tag_q [DEPTH];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            valid_q  <= {valid_q[DEPTH-2:0], in_valid_i};
            tag_q[0] <= in_tag_i;
            for (int i = 1; i < DEPTH; i++) begin
                tag_q[i] <= tag_q[i-1];
            end
        end
    end

    assign out_valid_o = valid_q[DEPTH-1];
    assign out_tag_o   = tag_q[DEPTH-1];

endmodule

// File: rtl/sdram_phy_io.sv
// Pin-side register stage for the SDRAM controller: registered command pins,
// write-data tristate ownership, tagged read capture and read/write turnaround.
module sdram_phy_io
    import sdram_pkg::*;
#(
    parameter int DATA_W       = 16,
    parameter int ADDR_W       = 13,
    parameter int BANK_W       = 2,
    parameter int CAS_LAT      = 2,
    parameter int RD_EXTRA_DLY = 0,
    parameter int TAG_W        = 4
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic [2:0]        cmd_op_i,
    input  logic              cmd_chip_i,
    input  logic [BANK_W-1:0] cmd_bank_i,
    input  logic [ADDR_W-1:0] cmd_addr_i,
    input  logic [DATA_W-1:0] cmd_wdata_i,
    input  logic [TAG_W-1:0]  cmd_tag_i,
    output logic              rd_valid_o,
    output logic [DATA_W-1:0] rd_data_o,
    output logic [TAG_W-1:0]  rd_tag_o,
    output logic              sdram_clk_o,
    output logic              sdram_cs_o,
    output logic [BANK_W-1:0] sdram_bank_o,
    output logic [ADDR_W-1:0] sdram_addr_o,
    output logic              sdram_ras_o,
    output logic              sdram_cas_o,
    output logic              sdram_we_o,
    output logic [DATA_W-1:0] sdram_data_out_o,
    output logic              sdram_drive_data_o,
    input  logic [DATA_W-1:0] sdram_data_in_i
);

    localparam int PIPE_DEPTH = CAS_LAT + 1 + RD_EXTRA_DLY;
    localparam int BUSY_W     = $clog2(CAS_LAT + 2);
    localparam logic [BUSY_W-1:0] BUSY_LOAD = BUSY_W'(CAS_LAT + 1);

    logic              accept;
    logic              acc_read;
    logic              acc_write;

    logic [2:0]        rcw_q,   rcw_d;
    logic              cs_q,    cs_d;
    logic [BANK_W-1:0] bank_q,  bank_d;
    logic [ADDR_W-1:0] addr_q,  addr_d;
    logic [DATA_W-1:0] dout_q,  dout_d;
    logic              drive_q, drive_d;
    logic [BUSY_W-1:0] busy_q,  busy_d;

    logic              pipe_valid;
    logic [TAG_W-1:0]  pipe_tag;
    logic              rd_valid_q, rd_valid_d;
    logic [DATA_W-1:0] rd_data_q,  rd_data_d;
    logic [TAG_W-1:0]  rd_tag_q,   rd_tag_d;

    // Ready must not look at cmd_valid so the core can hold a WRITE without a loop.
    assign cmd_ready_o = (cmd_op_i != 3'(CMD_WRITE)) || (busy_q == '0);
    assign accept      = cmd_valid_i && cmd_ready_o;
    assign acc_read    = accept && (cmd_op_i == 3'(CMD_READ));
    assign acc_write   = accept && (cmd_op_i == 3'(CMD_WRITE));

    always_comb begin
        rcw_d   = RCW_NOP;
        cs_d    = cs_q;
        bank_d  = bank_q;
        addr_d  = addr_q;
        dout_d  = dout_q;
        drive_d = 1'b0;
        if (accept) begin
            rcw_d  = cmd_to_rcw(cmd_op_i);
            cs_d   = cmd_chip_i;
            bank_d = cmd_bank_i;
            addr_d = cmd_addr_i;
        end
        if (acc_write) begin
            dout_d  = cmd_wdata_i;
            drive_d = 1'b1;
        end
    end

    // Reload on a new READ takes priority so back-to-back reads extend the window.
    always_comb begin
        busy_d = busy_q;
        if (acc_read) begin
            busy_d = BUSY_LOAD;
        end else if (busy_q != '0) begin
            busy_d = busy_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            rcw_q   <= RCW_NOP;
            cs_q    <= 1'b0;
            bank_q  <= '0;
            addr_q  <= '0;
            dout_q  <= '0;
            drive_q <= 1'b0;
            busy_q  <= '0;
        end else begin
            rcw_q   <= rcw_d;
            cs_q    <= cs_d;
            bank_q  <= bank_d;
            addr_q  <= addr_d;
            dout_q  <= dout_d;
            drive_q <= drive_d;
            busy_q  <= busy_d;
        end
    end

    sdram_rd_pipe #(
        .DEPTH (PIPE_DEPTH),
        .TAG_W (TAG_W)
    ) u_rd_pipe (
        .clk_i       (clk_i),
        .rst_i       (reset_i),
        .in_valid_i  (acc_read),
        .in_tag_i    (cmd_tag_i),
        .out_valid_o (pipe_valid),
        .out_tag_o   (pipe_tag)
    );

    // The capture flop is enabled only when a read is due, so it doubles as rd_data.
    always_comb begin
        rd_valid_d = pipe_valid;
        rd_data_d  = rd_data_q;
        rd_tag_d   = rd_tag_q;
        if (pipe_valid) begin
            rd_data_d = sdram_data_in_i;
            rd_tag_d  = pipe_tag;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            rd_tag_q   <= '0;
        end else begin
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
            rd_tag_q   <= rd_tag_d;
        end
    end

    assign sdram_clk_o        = ~clk_i;
    assign sdram_cs_o         = cs_q;
    assign sdram_bank_o       = bank_q;
    assign sdram_addr_o       = addr_q;
    assign sdram_ras_o        = rcw_q[2];
    assign sdram_cas_o        = rcw_q[1];
    assign sdram_we_o         = rcw_q[0];
    assign sdram_data_out_o   = dout_q;
    assign sdram_drive_data_o = drive_q;
    assign rd_valid_o         = rd_valid_q;
    assign rd_data_o          = rd_data_q;
    assign rd_tag_o           = rd_tag_q;

endmodule
